// File: rtl/t04_ack_arbiter_if.sv
// Handshake bundle between datapath, ack arbiter and the memory-mapped targets.
// slave = arbiter side, master = datapath/target side.
interface t04_ack_arbiter_if #(
  parameter int NUM_TGT = 3
) ();
  logic               i_req;
  logic               d_req;
  logic [NUM_TGT-1:0] tgt_sel;
  logic [NUM_TGT-1:0] tgt_done;
  logic [NUM_TGT-1:0] tgt_start;
  logic               i_ack;
  logic               d_ack;
  logic               err;
  logic               busy_o;

  modport slave (
    input  i_req, d_req, tgt_sel, tgt_done,
    output tgt_start, i_ack, d_ack, err, busy_o
  );

  modport master (
    output i_req, d_req, tgt_sel, tgt_done,
    input  tgt_start, i_ack, d_ack, err, busy_o
  );
endinterface

// File: rtl/t04_ack_arbiter.sv
// Instruction/data ack arbiter: one outstanding transaction, start pulse, single-cycle acks.
// Optional wait timeout with forced error ack is enabled by defining T04_ACK_TIMEOUT_EN.
module t04_ack_arbiter #(
  parameter int NUM_TGT     = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             nrst,
  t04_ack_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  // The timeout compare value must be representable in the counter.
  if ((CNT_W < 31) && ((1 << CNT_W) <= TIMEOUT_CYC)) begin : g_cfg_check
    $error("t04_ack_arbiter: CNT_W too small for TIMEOUT_CYC");
  end

  logic [1:0]         state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               instr_reg, instr_next;
  logic               err_reg, err_next;
  logic [NUM_TGT-1:0] idx_dec;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_onehot;
  logic               req_held;
  logic               done_hit;
  logic               timeout_hit;

  // Decoded latched index; gates both the start pulse and the done we listen to.
  for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_idx_dec
    assign idx_dec[gi] = (idx_reg == IDX_W'(gi));
  end

  assign sel_onehot = ($countones(bus.tgt_sel) == 1);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (bus.tgt_sel[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign req_held = instr_reg ? bus.i_req : bus.d_req;
  assign done_hit = |(bus.tgt_done & idx_dec);

`ifdef T04_ACK_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Counts WAIT cycles without done; saturates rather than wrapping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_LAUNCH) begin
      cnt_reg <= '0;
    end else if ((state_reg == ST_WAIT) && !done_hit && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_reg == ST_WAIT) && !done_hit &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    instr_next = instr_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.d_req) begin
          instr_next = 1'b0;
          if (sel_onehot) begin
            idx_next   = sel_idx;
            err_next   = 1'b0;
            state_next = ST_LAUNCH;
          end else begin
            // Decode error: acknowledge without touching any target.
            err_next   = 1'b1;
            state_next = ST_ACK;
          end
        end else if (bus.i_req) begin
          instr_next = 1'b1;
          idx_next   = '0;
          err_next   = 1'b0;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_hit) begin
          err_next   = 1'b0;
          state_next = ST_ACK;
        end else if (!req_held) begin
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      instr_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      instr_reg <= instr_next;
      err_reg   <= err_next;
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign bus.tgt_start = (state_reg == ST_LAUNCH) ? idx_dec : '0;
  assign bus.i_ack     = (state_reg == ST_ACK) && instr_reg;
  assign bus.d_ack     = (state_reg == ST_ACK) && !instr_reg;
  assign bus.err       = (state_reg == ST_ACK) && err_reg;
  assign bus.busy_o    = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_t04_ack_arbiter.sv
// Self-checking bench for t04_ack_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; T04_ACK_TIMEOUT_EN selects the timeout scenario.
module tb_t04_ack_arbiter;
  localparam int NT  = 3;
  localparam int TMO = 16;
`ifdef T04_ACK_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  t04_ack_arbiter_if #(.NUM_TGT(NT)) bus ();

  t04_ack_arbiter #(
    .NUM_TGT    (NT),
    .TIMEOUT_CYC(TMO),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Model: an open transaction, whether its launch cycle is next, and a pending ack.
  bit m_open, m_launch, m_instr, m_ack_due, m_ack_instr, m_ack_err;
  int m_idx, m_waits;

  function automatic int first_set(logic [NT-1:0] v);
    for (int i = 0; i < NT; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    logic [6:0]    exp_v, act_v;
    logic [NT-1:0] one_v;
    cyc++;
    one_v = 1;
    act_v = {bus.tgt_start, bus.i_ack, bus.d_ack, bus.err, bus.busy_o};
    if (!nrst) begin
      m_open = 0; m_launch = 0; m_instr = 0; m_ack_due = 0;
      m_ack_instr = 0; m_ack_err = 0; m_idx = 0; m_waits = 0;
      exp_v = '0;
    end else begin
      exp_v[6:4] = m_launch ? (one_v << m_idx) : '0;
      exp_v[3]   = m_ack_due && m_ack_instr;
      exp_v[2]   = m_ack_due && !m_ack_instr;
      exp_v[1]   = m_ack_due && m_ack_err;
      exp_v[0]   = m_open || m_ack_due;
    end
    n_vec++;
    if (act_v !== exp_v) begin
      n_miss++;
      $display("FAIL cycle_model cyc=%0d got start/iack/dack/err/busy=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
               cyc, act_v[6:4], act_v[3], act_v[2], act_v[1], act_v[0],
               exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
    if (nrst) begin
      if (m_ack_due) begin
        m_ack_due = 0;
      end else if (m_launch) begin
        m_launch = 0;
        m_waits  = 0;
      end else if (m_open) begin
        m_waits++;
        if (bus.tgt_done[m_idx]) begin
          m_open = 0; m_ack_due = 1; m_ack_instr = m_instr; m_ack_err = 0;
        end else if (!(m_instr ? bus.i_req : bus.d_req)) begin
          m_open = 0;
        end else if (TMO_ON && (m_waits == TMO)) begin
          m_open = 0; m_ack_due = 1; m_ack_instr = m_instr; m_ack_err = 1;
        end
      end else if (bus.d_req) begin
        if ($countones(bus.tgt_sel) == 1) begin
          m_open = 1; m_launch = 1; m_instr = 0; m_idx = first_set(bus.tgt_sel);
        end else begin
          m_ack_due = 1; m_ack_instr = 0; m_ack_err = 1;
        end
      end else if (bus.i_req) begin
        m_open = 1; m_launch = 1; m_instr = 1; m_idx = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req    = 1'b0;
    bus.d_req    = 1'b0;
    bus.tgt_sel  = '0;
    bus.tgt_done = '0;
  endtask

  function automatic int out_word();
    return int'({bus.tgt_start, bus.i_ack, bus.d_ack, bus.err, bus.busy_o});
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NT-1:0] pats [2];
    int k, acks;
    pats[0] = 3'b000;
    pats[1] = 3'b011;

    nrst = 1'b0;
    idle_inputs();
    #1 chk("reset_outputs", out_word(), 0);
    step(3);
    nrst = 1'b1;
    step(2);

    // Data to target 1, done four cycles after start; sel and foreign dones change mid-flight.
    bus.d_req = 1'b1; bus.tgt_sel = 3'b010;
    step(1); chk("t2_start", int'(bus.tgt_start), 2);
    bus.tgt_sel = 3'b100;
    bus.tgt_done = 3'b101;
    step(1); chk("t2_start_once", int'(bus.tgt_start), 0);
    step(3); chk("t2_no_early_ack", int'(bus.d_ack), 0);
    bus.tgt_done = 3'b010;
    step(1);
    chk("t2_dack", int'(bus.d_ack), 1);
    chk("t2_err", int'(bus.err), 0);
    chk("t2_iack", int'(bus.i_ack), 0);
    bus.d_req = 1'b0; bus.tgt_done = '0;
    step(1); chk("t2_idle", int'(bus.busy_o), 0);

    // Decode errors: zero-hot and multi-hot select.
    for (int p = 0; p < 2; p++) begin
      bus.d_req = 1'b1; bus.tgt_sel = pats[p];
      step(1);
      chk("t4_dack", int'(bus.d_ack), 1);
      chk("t4_err", int'(bus.err), 1);
      chk("t4_no_start", int'(bus.tgt_start), 0);
      bus.d_req = 1'b0;
      step(1); chk("t4_idle", int'(bus.busy_o), 0);
    end

    // Simultaneous requests: data first, then fetch.
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.tgt_sel = 3'b001;
    step(1); chk("t3_dstart", int'(bus.tgt_start), 1);
    step(1); bus.tgt_done = 3'b001;
    step(1);
    chk("t3_dack", int'(bus.d_ack), 1);
    chk("t3_no_iack", int'(bus.i_ack), 0);
    bus.d_req = 1'b0;
    step(1); chk("t3_idle_gap", int'(bus.tgt_start), 0);
    step(1); chk("t3_istart", int'(bus.tgt_start), 1);
    step(1); chk("t3_iack_not_yet", int'(bus.i_ack), 0);
    step(1);
    chk("t3_iack", int'(bus.i_ack), 1);
    chk("t3_no_dack", int'(bus.d_ack), 0);
    bus.i_req = 1'b0; bus.tgt_done = '0;
    step(1);

    // Stale done held high: ack no earlier than the third cycle.
    bus.tgt_done = 3'b001;
    step(1);
    bus.d_req = 1'b1; bus.tgt_sel = 3'b001;
    step(1); chk("t5_c1_no_ack", int'(bus.d_ack), 0);
    step(1); chk("t5_c2_no_ack", int'(bus.d_ack), 0);
    step(1); chk("t5_c3_ack", int'(bus.d_ack), 1);
    bus.d_req = 1'b0; bus.tgt_done = '0;
    step(1);

    // Abort during WAIT.
    bus.d_req = 1'b1; bus.tgt_sel = 3'b100;
    step(2);
    bus.d_req = 1'b0;
    step(1);
    chk("t5_abort_idle", int'(bus.busy_o), 0);
    chk("t5_abort_no_ack", int'(bus.d_ack), 0);
    step(3);

    // Reset asserted mid-WAIT.
    bus.d_req = 1'b1; bus.tgt_sel = 3'b010;
    step(4);
    chk("t1_busy_before", int'(bus.busy_o), 1);
    nrst = 1'b0;
    #1 chk("t1_reset_outputs", out_word(), 0);
    bus.d_req = 1'b0; bus.tgt_done = 3'b010;
    step(1);
    nrst = 1'b1;
    acks = 0;
    repeat (4) begin
      step(1);
      if (bus.d_ack || bus.i_ack) acks++;
    end
    chk("t1_no_ack_after_release", acks, 0);
    bus.tgt_done = '0;
    step(1);

`ifdef T04_ACK_TIMEOUT_EN
    bus.d_req = 1'b1; bus.tgt_sel = 3'b100;
    step(1);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (bus.d_ack) begin
        k = i;
        break;
      end
    end
    chk("t6_wait_cycles_before_ack", k - 1, TMO);
    chk("t6_err", int'(bus.err), 1);
    bus.d_req = 1'b0;
    step(2);
`else
    bus.d_req = 1'b1; bus.tgt_sel = 3'b100;
    acks = 0;
    repeat (1000) begin
      step(1);
      if (bus.d_ack || bus.i_ack) acks++;
    end
    chk("t6_no_ack_1000", acks, 0);
    chk("t6_still_busy", int'(bus.busy_o), 1);
    bus.d_req = 1'b0;
    step(2);
    chk("t6_released", int'(bus.busy_o), 0);
`endif

    // Randomized traffic: requests mostly held until acked, occasional aborts.
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      if (bus.d_ack) bus.d_req = 1'b0;
      if (bus.i_ack) bus.i_req = 1'b0;
      if (!bus.d_req && ($urandom_range(0, 3) == 0)) begin
        bus.d_req = 1'b1;
        if ($urandom_range(0, 9) < 7) bus.tgt_sel = NT'(1) << $urandom_range(0, NT - 1);
        else bus.tgt_sel = NT'($urandom_range(0, 7));
      end else if (bus.d_req && ($urandom_range(0, 9) == 0)) begin
        bus.tgt_sel = NT'($urandom_range(0, 7));
      end
      if (!bus.i_req && ($urandom_range(0, 3) == 0)) bus.i_req = 1'b1;
      for (int t = 0; t < NT; t++) bus.tgt_done[t] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.d_req = 1'b0; bus.i_req = 1'b0; bus.tgt_done = '0;
      end
      step(1);
    end

    idle_inputs();
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
